// File: rtl/zxiznet_cpld_if.sv
// ZXiznet host ZX-bus bundle: address, strobes and blocking outputs.
// Tristate data and the open-drain INT stay as plain inout ports.
interface zxiznet_cpld_if;
   logic [15:0] za;
   logic        ziorq_n;
   logic        zmreq_n;
   logic        zrd_n;
   logic        zwr_n;
   logic        zcsrom_n;
   logic        ziorqge;
   logic        zblkrom;

   modport master (
      output za, ziorq_n, zmreq_n, zrd_n, zwr_n, zcsrom_n,
      input  ziorqge, zblkrom
   );

   modport slave (
      input  za, ziorq_n, zmreq_n, zrd_n, zwr_n, zcsrom_n,
      output ziorqge, zblkrom
   );
endinterface

// File: rtl/zxiznet_cpld.sv
// ZXiznet glue: Z80 I/O + ROM-window decode onto W5300/SL811 bus.
// Optional macro ZXIZNET_EXT_INT_EN enables the host INT output.
module zxiznet_cpld (
   input  logic       clk,
   input  logic       zrst_n,
   zxiznet_cpld_if.slave zbus,
   inout  wire  [7:0] zd,
   inout  wire        zint_n,
   inout  wire  [7:0] bd,
   output logic       brd_n,
   output logic       bwr_n,
   output logic       w5300_rst_n,
   output logic       w5300_cs_n,
   output logic [9:0] w5300_addr,
   input  logic       w5300_int_n,
   output logic       sl811_rst_n,
   output logic       sl811_cs_n,
   output logic       sl811_a0,
   output logic       sl811_ms_n,
   input  logic       sl811_intrq,
   input  logic       usb_power
);

   logic       w_ien, s_ien, w_rst, s_rst, ext_ien;
   logic       ms;
   logic [1:0] rom;
   logic       sub_ena, a0_inv;

   logic       io_hit, p_sld, p_sla, p_sctl, p_wctl, p_ri;
   logic       access, sl_sel, win, periph;
   logic       int_w, int_s, int_any;
   logic [7:0] rd_data;
   logic [9:0] addr_raw;
   logic [13:0] m;

   assign io_hit = !zbus.ziorq_n && (zbus.za[7:0] == 8'hAB);
   assign p_sld  = io_hit && !zbus.za[15];
   assign p_sla  = io_hit && (zbus.za[15:8] == 8'h80);
   assign p_sctl = io_hit && (zbus.za[15:8] == 8'h81);
   assign p_wctl = io_hit && (zbus.za[15:8] == 8'h82);
   assign p_ri   = io_hit && (zbus.za[15:8] == 8'h83);

   assign access = !zbus.zrd_n || !zbus.zwr_n;
   assign sl_sel = (p_sld || p_sla) && access;
   assign win    = !zbus.zmreq_n && !zbus.zcsrom_n &&
                   (zbus.za[15:14] == rom) && sub_ena && access;
   assign periph = sl_sel || win;

   assign zbus.ziorqge = p_sld || p_sla || p_sctl || p_wctl || p_ri;
   assign zbus.zblkrom = win;

   assign sl811_cs_n  = !sl_sel;
   assign w5300_cs_n  = !win;
   assign sl811_a0    = p_sld;
   assign brd_n       = !(periph && !zbus.zrd_n);
   assign bwr_n       = !(periph && !zbus.zwr_n);
   assign sl811_ms_n  = !ms;
   assign w5300_rst_n = w_rst;
   assign sl811_rst_n = s_rst;

   assign int_w   = !w5300_int_n;
   assign int_s   = sl811_intrq;
   assign int_any = (int_w && w_ien) || (int_s && s_ien);

   // Control registers: cleared by reset, loaded on host I/O writes
   always_ff @(posedge clk) begin
      if (!zrst_n) begin
         w_ien   <= 1'b0;
         s_ien   <= 1'b0;
         w_rst   <= 1'b0;
         s_rst   <= 1'b0;
         ext_ien <= 1'b0;
         ms      <= 1'b0;
         rom     <= 2'b00;
         sub_ena <= 1'b0;
         a0_inv  <= 1'b0;
      end else if (!zbus.zwr_n) begin
         if (p_sctl) begin
            ms <= zd[0];
         end
         if (p_wctl) begin
            rom     <= zd[1:0];
            sub_ena <= zd[2];
            a0_inv  <= zd[3];
         end
         if (p_ri) begin
            w_ien <= zd[2];
            s_ien <= zd[3];
            w_rst <= zd[4];
            s_rst <= zd[5];
`ifdef ZXIZNET_EXT_INT_EN
            ext_ien <= zd[6];
`endif
         end
      end
   end

   // Host read mux: peripheral data or a control register image
   always_comb begin
      rd_data = 8'h00;
      unique case (1'b1)
         p_sld, p_sla, win: rd_data = bd;
         p_sctl: rd_data = {6'b0, usb_power, ms};
         p_wctl: rd_data = {4'b0, a0_inv, sub_ena, rom};
         p_ri: rd_data = {int_any, ext_ien, s_rst, w_rst,
                          s_ien, w_ien, int_s, int_w};
         default: rd_data = 8'h00;
      endcase
   end

   // Fold the 16K ROM window onto the W5300 10-bit address space
   always_comb begin
      m = zbus.za[13:0];
      addr_raw = m[9:0];
      if (m[13]) begin
         if (!m[12])
            addr_raw = {1'b1, m[11:9], 5'b10111, m[0]};
         else
            addr_raw = {1'b1, m[11:9], 5'b11000, m[0]};
      end
      w5300_addr = addr_raw ^ {9'b0, a0_inv};
   end

   assign zd = ((zbus.ziorqge || win) && !zbus.zrd_n) ? rd_data : 8'hzz;
   assign bd = (periph && !zbus.zwr_n) ? zd : 8'hzz;

`ifdef ZXIZNET_EXT_INT_EN
   assign zint_n = (ext_ien && int_any) ? 1'b0 : 1'bz;
`else
   assign zint_n = 1'bz;
`endif

endmodule

// File: tb/tb_zxiznet_cpld.sv
// Bench for zxiznet_cpld: spec-level register/decode model plus
// directed bus cycles; zint_n is pulled up so release reads as 1.
module tb_zxiznet_cpld;

   logic       clk = 1'b0;
   logic       zrst_n;
   wire  [7:0] zd;
   wire  [7:0] bd;
   wire        zint_n;
   logic       brd_n, bwr_n;
   logic       w5300_rst_n, w5300_cs_n;
   logic [9:0] w5300_addr;
   logic       w5300_int_n;
   logic       sl811_rst_n, sl811_cs_n, sl811_a0, sl811_ms_n;
   logic       sl811_intrq, usb_power;

   logic       host_drv;
   logic [7:0] host_d;
   logic [7:0] periph_q;
   logic       chk_en;

   int n_cmp = 0;
   int n_bad = 0;

   zxiznet_cpld_if bus ();

   pullup (zint_n);
   assign zd = host_drv ? host_d : 8'hzz;
   assign bd = (brd_n == 1'b0) ? periph_q : 8'hzz;

   zxiznet_cpld dut (
      .clk         (clk),
      .zrst_n      (zrst_n),
      .zbus        (bus),
      .zd          (zd),
      .zint_n      (zint_n),
      .bd          (bd),
      .brd_n       (brd_n),
      .bwr_n       (bwr_n),
      .w5300_rst_n (w5300_rst_n),
      .w5300_cs_n  (w5300_cs_n),
      .w5300_addr  (w5300_addr),
      .w5300_int_n (w5300_int_n),
      .sl811_rst_n (sl811_rst_n),
      .sl811_cs_n  (sl811_cs_n),
      .sl811_a0    (sl811_a0),
      .sl811_ms_n  (sl811_ms_n),
      .sl811_intrq (sl811_intrq),
      .usb_power   (usb_power)
   );

   always #35 clk = ~clk;

`ifdef ZXIZNET_EXT_INT_EN
   localparam logic [7:0] RI_MASK = 8'h7C;
   localparam bit EXT = 1'b1;
`else
   localparam logic [7:0] RI_MASK = 8'h3C;
   localparam bit EXT = 1'b0;
`endif

   // Model: byte image of writable bits of ports 0x81..0x83
   logic [7:0] mreg [1:3];

   function automatic logic [7:0] wmask(input logic [1:0] i);
      case (i)
         2'd1: return 8'h01;
         2'd2: return 8'h0F;
         default: return RI_MASK;
      endcase
   endfunction

   always @(posedge clk) begin
      if (!zrst_n) begin
         mreg[1] <= 8'h00;
         mreg[2] <= 8'h00;
         mreg[3] <= 8'h00;
      end else if (!bus.ziorq_n && !bus.zwr_n &&
                   bus.za[7:0] == 8'hAB &&
                   bus.za[15:8] >= 8'h81 && bus.za[15:8] <= 8'h83) begin
         mreg[bus.za[9:8]] <= host_d & wmask(bus.za[9:8]);
      end
   end

   function automatic logic m_int();
      return ((w5300_int_n == 1'b0) && mreg[3][2]) ||
             (sl811_intrq && mreg[3][3]);
   endfunction

   function automatic logic [7:0] m_read(input logic [1:0] i);
      logic [7:0] v;
      case (i)
         2'd1: v = {6'b0, usb_power, mreg[1][0]};
         2'd2: v = mreg[2];
         default: begin
            v = mreg[3];
            v[0] = !w5300_int_n;
            v[1] = sl811_intrq;
            v[7] = m_int();
         end
      endcase
      return v;
   endfunction

   function automatic logic [9:0] m_addr(input logic [13:0] a,
                                         input logic inv);
      int r;
      if (a < 14'h2000)
         r = a % 1024;
      else if (a < 14'h3000)
         r = 512 + ((a / 512) % 8) * 64 + 46 + (a % 2);
      else
         r = 512 + ((a / 512) % 8) * 64 + 48 + (a % 2);
      if (inv)
         r = (r % 2 == 1) ? r - 1 : r + 1;
      return r[9:0];
   endfunction

   task automatic chk(input string nm, input logic [15:0] act,
                      input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Per-cycle comparison of every meaningful output against the model
   always @(negedge clk) begin
      if (chk_en) begin
         logic io, dec, sld, sla, acc, sl, win, rd, wr;
         logic [7:0] pt;
         logic [7:0] ez;
         pt  = bus.za[15:8];
         rd  = !bus.zrd_n;
         wr  = !bus.zwr_n;
         acc = rd || wr;
         io  = !bus.ziorq_n && bus.za[7:0] == 8'hAB;
         dec = io && (!bus.za[15] || pt <= 8'h83);
         sld = io && !bus.za[15];
         sla = io && pt == 8'h80;
         sl  = (sld || sla) && acc;
         win = !bus.zmreq_n && !bus.zcsrom_n && acc &&
               bus.za[15:14] == mreg[2][1:0] && mreg[2][2];
         chk("ziorqge", bus.ziorqge, dec);
         chk("zblkrom", bus.zblkrom, win);
         chk("w5300_cs_n", w5300_cs_n, !win);
         chk("sl811_cs_n", sl811_cs_n, !sl);
         chk("brd_n", brd_n, !((sl || win) && rd));
         chk("bwr_n", bwr_n, !((sl || win) && wr));
         chk("w5300_rst_n", w5300_rst_n, mreg[3][4]);
         chk("sl811_rst_n", sl811_rst_n, mreg[3][5]);
         chk("sl811_ms_n", sl811_ms_n, !mreg[1][0]);
         chk("zint_n", zint_n, !(mreg[3][6] && m_int()));
         if (sl)
            chk("sl811_a0", sl811_a0, sld);
         if (win)
            chk("w5300_addr", w5300_addr,
                m_addr(bus.za[13:0], mreg[2][3]));
         if ((dec || win) && rd) begin
            ez = (sl || win) ? periph_q : m_read(pt[1:0]);
            chk("zd", zd, ez);
         end
         if ((sl || win) && wr)
            chk("bd", bd, host_d);
      end
   end

   task automatic bus_idle();
      bus.za       = 16'h0000;
      bus.ziorq_n  = 1'b1;
      bus.zmreq_n  = 1'b1;
      bus.zrd_n    = 1'b1;
      bus.zwr_n    = 1'b1;
      bus.zcsrom_n = 1'b1;
      host_drv     = 1'b0;
   endtask

   task automatic io_wr(input logic [15:0] a, input logic [7:0] d);
      @(posedge clk); #1;
      bus.za = a; host_d = d; host_drv = 1'b1;
      bus.ziorq_n = 1'b0; bus.zwr_n = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      bus_idle();
   endtask

   task automatic io_rd(input logic [15:0] a, output logic [7:0] d);
      @(posedge clk); #1;
      bus.za = a; bus.ziorq_n = 1'b0; bus.zrd_n = 1'b0;
      @(negedge clk);
      d = zd;
      @(posedge clk); #1;
      bus_idle();
   endtask

   task automatic mem_cyc(input logic [15:0] a, input logic w,
                          input logic [7:0] d);
      @(posedge clk); #1;
      bus.za = a; bus.zmreq_n = 1'b0; bus.zcsrom_n = 1'b0;
      if (w) begin
         host_d = d; host_drv = 1'b1; bus.zwr_n = 1'b0;
      end else begin
         bus.zrd_n = 1'b0;
      end
      @(posedge clk);
      @(posedge clk); #1;
      bus_idle();
   endtask

   initial begin
      logic [7:0] d;
      logic [7:0] ri [3];
      ri[0] = 8'h38; ri[1] = 8'h34; ri[2] = 8'h3C;
      bus_idle();
      host_d = 8'h00;
      periph_q = 8'h00;
      chk_en = 1'b0;
      zrst_n = 1'b0;
      w5300_int_n = 1'b1;
      sl811_intrq = 1'b0;
      usb_power = 1'b0;
      @(posedge clk); #1;
      chk_en = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_w5300_rst_n", w5300_rst_n, 1'b0);
      chk("rst_sl811_rst_n", sl811_rst_n, 1'b0);
      chk("rst_sl811_ms_n", sl811_ms_n, 1'b1);
      chk("rst_zint_n", zint_n, 1'b1);
      zrst_n = 1'b1;

      io_rd(16'h83AB, d);
      chk("rstint_after_rst", d, 8'h00);
      io_wr(16'h83AB, 8'h20);
      chk("sl811_rst_rel", {sl811_rst_n, w5300_rst_n}, 2'b10);
      io_wr(16'h83AB, 8'h30);
      chk("w5300_rst_rel", {sl811_rst_n, w5300_rst_n}, 2'b11);

      sl811_intrq = 1'b1;
      w5300_int_n = 1'b0;
      foreach (ri[i]) begin
         io_wr(16'h83AB, ri[i]);
         io_rd(16'h83AB, d);
         chk("int_bit7", d[7], 1'b1);
      end
      chk("zint_before_en", zint_n, 1'b1);
      io_wr(16'h83AB, 8'h7C);
      @(negedge clk);
      chk("zint_en", zint_n, !EXT);
      sl811_intrq = 1'b0;
      @(negedge clk);
      chk("zint_one_src", zint_n, !EXT);
      w5300_int_n = 1'b1;
      @(negedge clk);
      chk("zint_released", zint_n, 1'b1);

      io_wr(16'h81AB, 8'h00);
      chk("ms_n_0", sl811_ms_n, 1'b1);
      io_wr(16'h81AB, 8'h01);
      chk("ms_n_1", sl811_ms_n, 1'b0);
      io_rd(16'h81AB, d);
      chk("usb_pwr_0", d, 8'h01);
      usb_power = 1'b1;
      io_rd(16'h81AB, d);
      chk("usb_pwr_1", d, 8'h03);

      @(posedge clk); #1;
      bus.za = 16'h80AB; host_d = 8'h5A; host_drv = 1'b1;
      bus.ziorq_n = 1'b0; bus.zwr_n = 1'b0;
      @(negedge clk);
      chk("sl_wr_cs", {sl811_cs_n, sl811_a0, bwr_n}, 3'b000);
      chk("sl_wr_bd", bd, 8'h5A);
      @(posedge clk); #1;
      bus_idle();

      periph_q = 8'hC3;
      @(posedge clk); #1;
      bus.za = 16'h3FAB; bus.ziorq_n = 1'b0; bus.zrd_n = 1'b0;
      @(negedge clk);
      chk("sl_rd_zd", zd, 8'hC3);
      chk("sl_rd_a0", sl811_a0, 1'b1);
      @(posedge clk); #1;
      bus_idle();

      io_wr(16'h82AB, 8'h0D);
      periph_q = 8'h99;
      @(posedge clk); #1;
      bus.za = 16'h6A41; bus.zmreq_n = 1'b0;
      bus.zcsrom_n = 1'b0; bus.zrd_n = 1'b0;
      @(negedge clk);
      chk("win_addr", w5300_addr, 10'h36E);
      chk("win_blk", {bus.zblkrom, w5300_cs_n, brd_n}, 3'b100);
      chk("win_zd", zd, 8'h99);
      bus.za = 16'hAA41;
      @(negedge clk);
      chk("win_other_rom", {bus.zblkrom, w5300_cs_n, brd_n}, 3'b011);
      @(posedge clk); #1;
      bus_idle();
      io_wr(16'h82AB, 8'h09);
      mem_cyc(16'h6A41, 1'b0, 8'h00);
      mem_cyc(16'h6A41, 1'b1, 8'h11);

      io_wr(16'h82AB, 8'h06);
      periph_q = 8'h5E;
      mem_cyc(16'h8123, 1'b1, 8'hA7);
      mem_cyc(16'h9FFF, 1'b0, 8'h00);
      mem_cyc(16'hA000, 1'b0, 8'h00);
      mem_cyc(16'hAFFF, 1'b1, 8'h3C);
      mem_cyc(16'hB001, 1'b0, 8'h00);
      mem_cyc(16'hBFFE, 1'b1, 8'hE1);
      io_wr(16'h82AB, 8'h0E);
      mem_cyc(16'hB200, 1'b0, 8'h00);
      mem_cyc(16'h8000, 1'b0, 8'h00);
      io_rd(16'h82AB, d);
      chk("wctl_read", d, 8'h0E);

      @(posedge clk); #1;
      bus.za = 16'h84AB; bus.ziorq_n = 1'b0; bus.zrd_n = 1'b0;
      @(negedge clk);
      chk("port84_undec", {bus.ziorqge, brd_n}, 2'b01);
      bus.za = 16'hFFAB;
      @(negedge clk);
      chk("portFF_undec", {bus.ziorqge, brd_n}, 2'b01);
      bus.za = 16'h12AB;
      periph_q = 8'h3C;
      @(posedge clk); #1;
      zrst_n = 1'b0;
      @(posedge clk); #1;
      chk("midrst_chips", {w5300_rst_n, sl811_rst_n}, 2'b00);
      chk("midrst_strobe", {sl811_cs_n, brd_n}, 2'b00);
      @(negedge clk);
      chk("midrst_zd", zd, 8'h3C);
      @(posedge clk); #1;
      zrst_n = 1'b1;
      bus_idle();

      io_wr(16'h83AB, 8'hFF);
      io_rd(16'h83AB, d);
      chk("ri_mask", d, RI_MASK);
      io_wr(16'h81AB, 8'hFE);
      chk("sctl_mask", sl811_ms_n, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
